// File: rtl/audio_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the audio gain stage.
package audio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned GAIN_W = 3;

  localparam logic [DATA_W-1:0] SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSend
  } state_e;

endpackage

// File: rtl/audio_sat_shift.sv
// Combinational arithmetic left shift of a signed sample with saturation to the
// sample range; clip flags that saturation occurred.
module audio_sat_shift #(
  parameter int unsigned DATA_W = audio_pkg::DATA_W,
  parameter int unsigned GAIN_W = audio_pkg::GAIN_W
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [GAIN_W-1:0] shift,
  output logic [DATA_W-1:0] result,
  output logic              clip
);

  localparam int unsigned ExtW = DATA_W + (2 ** GAIN_W) - 1;

  logic signed [ExtW-1:0]   prod;
  logic        [ExtW-DATA_W:0] top_bits;

  always_comb begin
    prod     = $signed({{(ExtW - DATA_W){sample[DATA_W-1]}}, sample}) <<< shift;
    // In range only if every bit above the result's sign bit matches it.
    top_bits = prod[ExtW-1:DATA_W-1];
    clip     = !((&top_bits) || (~|top_bits));
    if (!clip) begin
      result = prod[DATA_W-1:0];
    end else if (prod[ExtW-1]) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/audio_gain_stage.sv
// Capture-to-playback gain stage: reads a stereo pair, applies a ramped shift gain
// with saturation (or mute/bypass), then holds it until playback accepts it.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W    = audio_pkg::DATA_W,
  parameter int unsigned GAIN_W    = audio_pkg::GAIN_W,
  parameter int unsigned CLIP_HOLD = 2500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_available,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_read,
  input  logic              out_allowed,
  output logic              out_write,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic              bypass,
  input  logic              mute,
  output logic [GAIN_W-1:0] gain_cur,
  output logic              clip
);

  localparam int unsigned CntW = $clog2(CLIP_HOLD + 1);

  state_e            state_q;
  logic [DATA_W-1:0] lat_left_q, lat_right_q;
  logic [DATA_W-1:0] sat_left, sat_right;
  logic              sat_clip_left, sat_clip_right;
  logic [GAIN_W-1:0] gain_next;
  logic [CntW-1:0]   clip_cnt_q;

  // Step at most one toward the target per sample to avoid zipper noise.
  always_comb begin
    gain_next = gain_cur;
    if (gain_target > gain_cur) begin
      gain_next = gain_cur + GAIN_W'(1);
    end else if (gain_target < gain_cur) begin
      gain_next = gain_cur - GAIN_W'(1);
    end
  end

  audio_sat_shift #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_sat_left (
    .sample (lat_left_q),
    .shift  (gain_next),
    .result (sat_left),
    .clip   (sat_clip_left)
  );

  audio_sat_shift #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_sat_right (
    .sample (lat_right_q),
    .shift  (gain_next),
    .result (sat_right),
    .clip   (sat_clip_right)
  );

  // Strobes are gated by reset so an in-flight sample is never written out.
  assign in_read   = !reset && (state_q == StIdle) && in_available;
  assign out_write = !reset && (state_q == StSend) && out_allowed;
  assign clip      = (clip_cnt_q != '0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      lat_left_q  <= '0;
      lat_right_q <= '0;
      out_left    <= '0;
      out_right   <= '0;
      gain_cur    <= '0;
      clip_cnt_q  <= '0;
    end else begin
      if (clip_cnt_q != '0) begin
        clip_cnt_q <= clip_cnt_q - CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (in_available) begin
            lat_left_q  <= in_left;
            lat_right_q <= in_right;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          gain_cur <= gain_next;
          if (mute) begin
            out_left  <= '0;
            out_right <= '0;
          end else if (bypass) begin
            out_left  <= lat_left_q;
            out_right <= lat_right_q;
          end else begin
            out_left  <= sat_left;
            out_right <= sat_right;
            if (sat_clip_left || sat_clip_right) begin
              clip_cnt_q <= CntW'(CLIP_HOLD);
            end
          end
          state_q <= StSend;
        end
        StSend: begin
          if (out_allowed) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed and randomized bench for audio_gain_stage against an arithmetic reference model.
module tb_audio_gain_stage;
  import audio_pkg::*;

  localparam int unsigned HOLD = 10;

  logic        CLOCK_50     = 1'b0;
  logic        reset        = 1'b1;
  logic        in_available = 1'b0;
  logic        out_allowed  = 1'b0;
  logic        bypass       = 1'b0;
  logic        mute         = 1'b0;
  logic [31:0] in_left      = '0;
  logic [31:0] in_right     = '0;
  logic [2:0]  gain_target  = '0;
  logic        in_read, out_write, clip;
  logic [31:0] out_left, out_right;
  logic [2:0]  gain_cur;

  int   checks = 0;
  int   errors = 0;
  int   model_gain = 0;
  logic sent_clip;
  int   sent_gain;

  audio_gain_stage #(
    .DATA_W    (32),
    .GAIN_W    (3),
    .CLIP_HOLD (HOLD)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .in_available (in_available),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_read      (in_read),
    .out_allowed  (out_allowed),
    .out_write    (out_write),
    .out_left     (out_left),
    .out_right    (out_right),
    .gain_target  (gain_target),
    .bypass       (bypass),
    .mute         (mute),
    .gain_cur     (gain_cur),
    .clip         (clip)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer multiply by 2^shift, then clamp to the 32-bit range.
  function automatic logic [31:0] ref_sat(input logic [31:0] s, input int sh);
    longint v, p, lim_hi, lim_lo;
    p      = 1;
    p      = p << sh;
    v      = longint'($signed(s)) * p;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    if (v > lim_hi) return SAMPLE_MAX;
    if (v < lim_lo) return SAMPLE_MIN;
    return v[31:0];
  endfunction

  // Entered at negedge+1 with the DUT idle; leaves at the negedge+1 after the transfer.
  task automatic run_sample(input logic [31:0] l, input logic [31:0] r, input int stall);
    logic [31:0] el, er;
    if (model_gain < int'(gain_target)) model_gain++;
    else if (model_gain > int'(gain_target)) model_gain--;
    el = mute ? 32'h0 : (bypass ? l : ref_sat(l, model_gain));
    er = mute ? 32'h0 : (bypass ? r : ref_sat(r, model_gain));
    in_left = l; in_right = r; in_available = 1'b1; out_allowed = (stall == 0);
    #1;
    chk("idle_read", in_read, 1);
    chk("idle_write", out_write, 0);
    @(negedge CLOCK_50);
    in_left = $urandom; in_right = $urandom;
    #1;
    chk("calc_read", in_read, 0);
    chk("calc_write", out_write, 0);
    @(negedge CLOCK_50); #1;
    for (int i = 0; i < stall; i++) begin
      chk("bp_write", out_write, 0);
      chk("bp_read", in_read, 0);
      chk("bp_left", out_left, el);
      chk("bp_right", out_right, er);
      @(negedge CLOCK_50); #1;
    end
    out_allowed = 1'b1;
    #1;
    chk("send_write", out_write, 1);
    chk("send_read", in_read, 0);
    chk("send_left", out_left, el);
    chk("send_right", out_right, er);
    chk("send_gain", 32'(gain_cur), 32'(model_gain));
    sent_clip = clip;
    sent_gain = int'(gain_cur);
    @(negedge CLOCK_50);
    in_available = 1'b0;
    #1;
    chk("post_write", out_write, 0);
  endtask

  initial begin
    int cnt;
    int exp_ramp[5];
    logic [31:0] tl, tr;
    exp_ramp = '{4, 3, 2, 1, 1};

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50); #1;
    chk("rst_left", out_left, 0);
    chk("rst_right", out_right, 0);
    chk("rst_gain", 32'(gain_cur), 0);
    chk("rst_clip", clip, 0);
    chk("rst_read", in_read, 0);
    chk("rst_write", out_write, 0);

    // Basic pass with gain ramp 0->1->2
    gain_target = 3'd2;
    run_sample(32'h0000_0100, 32'hFFFF_FF00, 0);
    chk("ramp_first", sent_gain, 1);
    run_sample(32'h0000_0100, 32'hFFFF_FF00, 0);
    chk("ramp_second", sent_gain, 2);
    chk("basic_left", out_left, 32'h0000_0400);
    chk("basic_right", out_right, 32'hFFFF_FC00);

    // Saturation and clip stretch
    gain_target = 3'd7;
    repeat (5) run_sample(32'h0000_0010, 32'hFFFF_FFF0, 0);
    chk("pre_clip", clip, 0);
    run_sample(32'h0200_0000, 32'hFC00_0000, 0);
    chk("sat_left", out_left, 32'h7FFF_FFFF);
    chk("sat_right", out_right, 32'h8000_0000);
    chk("clip_rise", sent_clip, 1);
    cnt = 1;
    while (clip && cnt < 40) begin
      cnt++;
      @(negedge CLOCK_50); #1;
    end
    chk("clip_len", cnt, HOLD);
    chk("clip_fall", clip, 0);

    // Backpressure: 20 stalled cycles in SEND
    run_sample(32'h0000_0123, 32'hFFFF_F000, 20);

    // Mute beats bypass, then bypass passes unchanged
    gain_target = 3'd3;
    mute = 1'b1; bypass = 1'b1;
    run_sample(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    chk("mute_left", out_left, 0);
    chk("mute_clip", sent_clip, 0);
    mute = 1'b0;
    run_sample(32'h7FFF_FFFF, 32'h8000_0000, 0);
    chk("bypass_left", out_left, 32'h7FFF_FFFF);
    chk("bypass_clip", sent_clip, 0);
    bypass = 1'b0;

    // Reset asserted while the sample is in CALC
    in_left = 32'h0000_1000; in_right = 32'h0000_2000;
    in_available = 1'b1; out_allowed = 1'b1;
    #1;
    chk("mid_read", in_read, 1);
    @(negedge CLOCK_50);
    reset = 1'b1; in_available = 1'b0;
    #1;
    chk("mid_write", out_write, 0);
    @(negedge CLOCK_50); #1;
    reset = 1'b0;
    model_gain = 0;
    chk("mid_left", out_left, 0);
    chk("mid_right", out_right, 0);
    chk("mid_gain", 32'(gain_cur), 0);
    chk("mid_clip", clip, 0);
    repeat (3) begin
      @(negedge CLOCK_50); #1;
      chk("mid_nowrite", out_write, 0);
    end

    // Ramp down 5 -> 1
    gain_target = 3'd5;
    repeat (5) run_sample(32'h0000_0001, 32'hFFFF_FFFF, 0);
    chk("ramp_up5", sent_gain, 5);
    gain_target = 3'd1;
    for (int i = 0; i < 5; i++) begin
      run_sample($urandom_range(0, 65535), $urandom_range(0, 65535), 0);
      chk("ramp_down", sent_gain, exp_ramp[i]);
    end

    // Randomized samples, gains, modes and backpressure
    repeat (25) begin
      gain_target = 3'($urandom_range(0, 7));
      mute   = ($urandom_range(0, 7) == 0);
      bypass = ($urandom_range(0, 5) == 0);
      tl = $urandom; tr = $urandom;
      tl = $signed(tl) >>> $urandom_range(0, 30);
      tr = $signed(tr) >>> $urandom_range(0, 30);
      run_sample(tl, tr, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
